// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and defaults for the UART receive FIFO.
package uart_rx_fifo_pkg;

  localparam int DEFAULT_DEPTH_LOG2 = 4;

  typedef logic [7:0] byte_t;

  // Resolved per-cycle operation, after flush priority and full/empty gating.
  typedef struct packed {
    logic flush;
    logic push;
    logic pop;
    logic drop;
  } fifo_op_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO between uart_rx and the MMIO decoder: show-ahead head
// byte, occupancy status, sticky overflow and a registered threshold interrupt.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int IRQ_THRESH = 1
) (
  input  logic                  I_clk,
  input  logic                  I_reset,
  input  logic                  I_wr,
  input  logic [7:0]            I_wr_data,
  input  logic                  I_rd,
  input  logic                  I_flush,
  input  logic                  I_clr_ovf,
  output logic [7:0]            O_rd_data,
  output logic                  O_empty,
  output logic                  O_full,
  output logic [DEPTH_LOG2:0]   O_count,
  output logic                  O_overflow,
  output logic                  O_irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t PTR_ONE = ptr_t'(1);
  localparam ptr_t THRESH  = ptr_t'(IRQ_THRESH);

  byte_t    mem [DEPTH];
  ptr_t     wr_ptr_q, wr_ptr_d;
  ptr_t     rd_ptr_q, rd_ptr_d;
  ptr_t     occupancy, occupancy_d;
  logic     overflow_q, overflow_d;
  logic     irq_q, irq_d;
  logic     empty, full;
  fifo_op_t op;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    occupancy = wr_ptr_q - rd_ptr_q;
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);

    // Flush swallows any push/pop in the same cycle, including one that would overflow.
    op       = '0;
    op.flush = I_flush;
    op.push  = !I_flush && I_wr && (!full || I_rd);
    op.pop   = !I_flush && I_rd && !empty;
    op.drop  = !I_flush && I_wr && full && !I_rd;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (op.push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (op.flush)    rd_ptr_d = wr_ptr_q;
    else if (op.pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

    overflow_d = overflow_q;
    if (op.drop)         overflow_d = 1'b1;
    else if (I_clr_ovf)  overflow_d = 1'b0;

    occupancy_d = wr_ptr_d - rd_ptr_d;
    irq_d       = (occupancy_d >= THRESH);
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge I_clk) begin
    if (op.push) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= I_wr_data;
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  assign O_rd_data  = empty ? 8'h00 : mem[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign O_empty    = empty;
  assign O_full     = full;
  assign O_count    = occupancy;
  assign O_overflow = overflow_q;
  assign O_irq      = irq_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer between `uart_rx` and the system memory-mapped I/O decoder. It captures every byte strobed out of `uart_rx` into a circular FIFO, so bytes are no longer lost when the CPU is slow to read `UART_1_RW`. It presents the head byte, empty/full/count status, a sticky overflow flag, and a level interrupt request to the system block and irq observer.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `IRQ_THRESH`, default 1: `O_irq` asserts when the occupancy is at least this value. Legal range is 1..2^DEPTH_LOG2.

Ports:
- `I_clk` in 1: clock.
- `I_reset` in 1: reset, synchronous, active-high.
- `I_wr` in 1: one-cycle push strobe, driven by `uart_rx` `O_data_ready`.
- `I_wr_data` in 8: byte to push, driven by `uart_rx` `O_data`.
- `I_rd` in 1: one-cycle pop strobe from the system decoder on a CPU read of `UART_1_RW`.
- `I_flush` in 1: one-cycle strobe that discards all contents.
- `I_clr_ovf` in 1: one-cycle strobe that clears `O_overflow`.
- `O_rd_data` out 8: head byte (show-ahead). Reads 8'h00 when empty.
- `O_empty` out 1: occupancy is 0.
- `O_full` out 1: occupancy is 2^DEPTH_LOG2.
- `O_count` out DEPTH_LOG2+1: occupancy.
- `O_overflow` out 1: sticky, set when a push is dropped.
- `O_irq` out 1: registered level, `O_count >= IRQ_THRESH`.

## Operation
- Storage is an array of 2^DEPTH_LOG2 × 8 bits.
- `wr_ptr` and `rd_ptr` are DEPTH_LOG2+1 bits wide. The MSB is the wrap bit; the low bits index the array.
- Pointers wrap naturally modulo 2^(DEPTH_LOG2+1).
- `O_count = wr_ptr - rd_ptr`, computed modulo 2^(DEPTH_LOG2+1).
- `O_empty` means the pointers are equal. `O_full` means the low bits are equal and the MSBs differ.
- A push is accepted when `I_wr` is high and the FIFO is not full, or when it is full and `I_rd` is high in the same cycle. An accepted push writes `mem[wr_ptr]` and increments `wr_ptr`.
- When a push is refused (full, no simultaneous pop):
  - The byte is dropped.
  - `O_overflow` is set.
  - Contents are unchanged.
- A pop is accepted when `I_rd` is high and the FIFO is not empty; it increments `rd_ptr`.
- A pop on an empty FIFO is ignored. This holds even when a push arrives in the same cycle: the pushed byte stays.
- Simultaneous accepted push and pop leave `O_count` unchanged.
- `I_flush` sets `rd_ptr` to `wr_ptr`. It takes priority over `I_wr` and `I_rd` in the same cycle, so that push is discarded and no overflow is raised. `O_overflow` is not changed by flush.
- `O_overflow` clears only on `I_clr_ovf` or reset. If a set event and `I_clr_ovf` occur in the same cycle, the set wins.
- `O_rd_data` is a combinational read of `mem[rd_ptr[DEPTH_LOG2-1:0]]`, gated to 0 when empty.

## Timing
- Reset values:
  - `wr_ptr = rd_ptr = 0`.
  - `O_empty = 1`, `O_full = 0`, `O_count = 0`.
  - `O_overflow = 0`, `O_irq = 0`, `O_rd_data = 0`.
  - Array contents are not reset.
- Reset mid-stream drops all data. The first push after reset lands at index 0.
- Push at edge N: `O_empty`, `O_count` and `O_rd_data` reflect the new byte from cycle N+1.
- Pop at edge N: the next byte appears on `O_rd_data` in cycle N+1. The system decoder samples `O_rd_data` in the same cycle it asserts `I_rd`.
- `O_irq` is registered from the next-state count, so it updates in the same cycle as `O_count` with no extra latency.
- Throughput is one push and one pop per cycle.
- `I_wr`, `I_rd`, `I_flush` and `I_clr_ovf` are single-cycle strobes. A strobe held for k cycles acts as k operations.

## Structure
- `mmap.vh` gains:
  - `UART_1_RX_STATUS` address.
  - Status bit positions: bit0 not-empty, bit1 full, bit2 overflow. Writing 1 to bit2 generates `I_clr_ovf`.
  - `UART_1_RX_FLUSH` address.
- `UART_1_RX_DATA_READY` maps to `!O_empty`.
- `O_irq` feeds the irq observer as interrupt source 1, replacing the single-byte `rx_data` buffer.
- Single flat module with no sub-module; storage is an inline array, inferred as distributed RAM.

## Test plan
- Reset, then push 8'hA5: after 1 cycle, `O_empty=0`, `O_count=1`, `O_rd_data=8'hA5`, `O_irq=1`. Pop: `O_empty=1`, `O_rd_data=0`.
- Push 0x00..0x0F (16 bytes): `O_full=1`, `O_count=16`. Push 0x10: dropped, `O_overflow=1`. Pop 16 times: read 0x00..0x0F in order, then empty.
- FIFO full, simultaneous push 0x55 and pop: count stays 16, overflow stays 0, last byte popped is 0x55.
- FIFO empty, simultaneous push 0x33 and pop: `O_count=1`, `O_rd_data=0x33`.
- Wrap-around: 40 push/pop pairs with random gaps. Data matches a reference queue; `O_count` is never above 16.
- Corner cases:
  - Flush with push in the same cycle: empty and no overflow.
  - Overflow and `I_clr_ovf` in the same cycle: `O_overflow=1`.
  - `I_reset` with 5 bytes queued: all outputs return to their reset values the next cycle.
